// File: rtl/clock_group_reset_sequencer_pkg.sv
// Shared clock-group definitions: sequencer state encoding, timing defaults
// and width helpers reused by the clock-group nodes.
package clock_group_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ASSERT  = 2'd1,
        RELEASE = 2'd2,
        DONE    = 2'd3
    } cg_state_e;

    localparam int unsigned DEFAULT_STRETCH_CYCLES = 16;
    localparam int unsigned DEFAULT_STAGGER_CYCLES = 4;

    // Counter must hold the larger of the two intervals without wrapping.
    function automatic int unsigned cnt_width(input int unsigned stretch,
                                              input int unsigned stagger);
        int unsigned longest;
        longest = (stretch > stagger) ? stretch : stagger;
        return $clog2(longest + 1);
    endfunction

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned CNT_W = cnt_width(DEFAULT_STRETCH_CYCLES, DEFAULT_STAGGER_CYCLES);

endpackage

// File: rtl/clock_group_reset_sequencer_if.sv
// Soft-reset request handshake and per-member reset fan-out of the
// clock-group reset sequencer.
interface clock_group_reset_sequencer_if #(
    parameter int unsigned N_MEMBERS = 4
);
    logic                 io_sw_req_valid;
    logic                 io_sw_req_ready;
    logic [N_MEMBERS-1:0] io_sw_req_mask;
    logic [N_MEMBERS-1:0] io_member_reset;
    logic                 io_busy;
    logic                 io_done;

    modport master (
        output io_sw_req_valid,
        output io_sw_req_mask,
        input  io_sw_req_ready,
        input  io_member_reset,
        input  io_busy,
        input  io_done
    );

    modport slave (
        input  io_sw_req_valid,
        input  io_sw_req_mask,
        output io_sw_req_ready,
        output io_member_reset,
        output io_busy,
        output io_done
    );
endinterface

// File: rtl/clock_group_reset_sequencer_next_member_sel.sv
// Picks the lowest-indexed member still awaiting release and flags whether
// it is the only one left.
module next_member_sel #(
    parameter int unsigned N_MEMBERS = 4,
    parameter int unsigned IDX_W     = 2
) (
    input  logic [N_MEMBERS-1:0] remaining,
    output logic [IDX_W-1:0]     idx,
    output logic                 last
);

    always_comb begin
        idx = '0;
        for (int i = int'(N_MEMBERS) - 1; i >= 0; i--) begin
            if (remaining[i]) idx = IDX_W'(i);
        end
        last = (remaining != '0) &&
               ((remaining & (remaining - N_MEMBERS'(1))) == '0);
    end

endmodule

// File: rtl/clock_group_reset_sequencer.sv
// Holds member resets after a group reset or soft request, then releases
// them one by one in ascending index order and signals completion.
module clock_group_reset_sequencer
    import clock_group_pkg::*;
#(
    parameter int unsigned N_MEMBERS      = 4,
    parameter int unsigned STRETCH_CYCLES = DEFAULT_STRETCH_CYCLES,
    parameter int unsigned STAGGER_CYCLES = DEFAULT_STAGGER_CYCLES
) (
    input  logic                          clock,
    input  logic                          reset,
    clock_group_reset_sequencer_if.slave  bus
);

    localparam int unsigned CW    = cnt_width(STRETCH_CYCLES, STAGGER_CYCLES);
    localparam int unsigned IDX_W = idx_width(N_MEMBERS);

    cg_state_e            state, state_d;
    logic [CW-1:0]        cnt, cnt_d;
    logic [N_MEMBERS-1:0] remaining, remaining_d;
    logic [N_MEMBERS-1:0] member_q, member_d;
    logic                 post_reset, post_reset_d;
    logic                 ready_q, ready_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic [IDX_W-1:0]     sel_idx;
    logic                 sel_last;
    logic [N_MEMBERS-1:0] sel_onehot;

    next_member_sel #(
        .N_MEMBERS (N_MEMBERS),
        .IDX_W     (IDX_W)
    ) u_sel (
        .remaining (remaining),
        .idx       (sel_idx),
        .last      (sel_last)
    );

    assign sel_onehot = N_MEMBERS'(1) << sel_idx;

    // Next-state, counter and next-output logic
    always_comb begin
        state_d      = state;
        cnt_d        = cnt;
        remaining_d  = remaining;
        member_d     = member_q;
        post_reset_d = 1'b0;

        case (state)
            IDLE: begin
                if (bus.io_sw_req_valid && ready_q) begin
                    remaining_d = bus.io_sw_req_mask;
                    member_d    = member_q | bus.io_sw_req_mask;
                    cnt_d       = '0;
                    state_d     = ASSERT;
                end
            end
            ASSERT: begin
                // The first edge after group reset is the trigger, so it does not count.
                if (remaining == '0) begin
                    state_d = DONE;
                end else if (post_reset) begin
                    cnt_d = '0;
                end else if (cnt == CW'(STRETCH_CYCLES - 1)) begin
                    member_d    = member_q & ~sel_onehot;
                    remaining_d = remaining & ~sel_onehot;
                    cnt_d       = '0;
                    state_d     = sel_last ? DONE : RELEASE;
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
            RELEASE: begin
                if (cnt == CW'(STAGGER_CYCLES - 1)) begin
                    member_d    = member_q & ~sel_onehot;
                    remaining_d = remaining & ~sel_onehot;
                    cnt_d       = '0;
                    if (sel_last) state_d = DONE;
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        ready_d = (state_d == IDLE);
        busy_d  = (state_d != IDLE);
        done_d  = (state_d == DONE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ASSERT;
            cnt        <= '0;
            remaining  <= '1;
            member_q   <= '1;
            post_reset <= 1'b1;
            ready_q    <= 1'b0;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            remaining  <= remaining_d;
            member_q   <= member_d;
            post_reset <= post_reset_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.io_member_reset = member_q;
    assign bus.io_sw_req_ready = ready_q;
    assign bus.io_busy         = busy_q;
    assign bus.io_done         = done_q;

endmodule

// File: tb/tb_clock_group_reset_sequencer.sv
// Bench for the clock-group reset sequencer: directed scenarios, a request
// table and randomized traffic checked against a release-schedule model.
module tb_clock_group_reset_sequencer;

    localparam int unsigned N = 4;
    localparam int          S = 16;
    localparam int          G = 4;

    logic clk = 1'b0;
    logic rst;

    clock_group_reset_sequencer_if #(.N_MEMBERS(N)) bus ();

    clock_group_reset_sequencer #(
        .N_MEMBERS      (N),
        .STRETCH_CYCLES (S),
        .STAGGER_CYCLES (G)
    ) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    function automatic void check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    task automatic adv(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_idle(input string name);
        for (int k = 0; k < 200; k++) begin
            if (bus.io_sw_req_ready === 1'b1) break;
            @(negedge clk);
        end
        check(name, int'(bus.io_sw_req_ready), 1);
    endtask

    // Reference model: every trigger fixes an absolute fall time per member
    int             ecount = 0;
    logic [N-1:0]   m_rst  = '0;
    logic           m_ready = 1'b0;
    logic           m_busy  = 1'b0;
    logic           m_done  = 1'b0;
    int             fall [N];
    int             t_done = 0;

    function automatic void schedule(input int t0, input logic [N-1:0] mk);
        int k;
        k = 0;
        for (int i = 0; i < int'(N); i++) begin
            if (mk[i]) begin
                fall[i] = t0 + S + k * G;
                k++;
            end else begin
                fall[i] = -1;
            end
        end
        t_done = (k == 0) ? t0 + 1 : t0 + S + (k - 1) * G;
    endfunction

    task automatic model_edge(input logic r, input logic v, input logic [N-1:0] mk);
        ecount++;
        if (r) begin
            m_rst = '1; m_ready = 1'b0; m_busy = 1'b1; m_done = 1'b0;
            schedule(ecount + 1, '1);
        end else if (m_ready && v) begin
            m_rst = m_rst | mk; m_ready = 1'b0; m_busy = 1'b1; m_done = 1'b0;
            schedule(ecount, mk);
        end else if (m_busy) begin
            for (int i = 0; i < int'(N); i++)
                if (fall[i] == ecount) m_rst[i] = 1'b0;
            m_done = (ecount == t_done);
            if (ecount == t_done + 1) begin
                m_busy = 1'b0; m_ready = 1'b1;
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_edge(rst, bus.io_sw_req_valid, bus.io_sw_req_mask);
    end

    initial forever begin
        @(negedge clk);
        if (ecount > 0) begin
            check("mon_member_reset", int'(bus.io_member_reset), int'(m_rst));
            check("mon_ready", int'(bus.io_sw_req_ready), int'(m_ready));
            check("mon_busy", int'(bus.io_busy), int'(m_busy));
            check("mon_done", int'(bus.io_done), int'(m_done));
        end
    end

    typedef struct {
        logic [N-1:0] mask;
        logic [N-1:0] acc;
        int           done_off;
        int           first_fall;
    } vec_t;

    vec_t tv [6];

    initial begin
        tv[0] = '{4'b1010, 4'b1010, 20, 16};
        tv[1] = '{4'b0000, 4'b0000,  1, -1};
        tv[2] = '{4'b0001, 4'b0001, 16, 16};
        tv[3] = '{4'b1111, 4'b1111, 28, 16};
        tv[4] = '{4'b0110, 4'b0110, 20, 16};
        tv[5] = '{4'b1000, 4'b1000, 16, 16};

        rst = 1'b1;
        bus.io_sw_req_valid = 1'b0;
        bus.io_sw_req_mask  = '0;

        // Power-on: hold, then staggered release from the first reset-low edge
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("por_member_reset", int'(bus.io_member_reset), 15);
            check("por_ready", int'(bus.io_sw_req_ready), 0);
            check("por_busy", int'(bus.io_busy), 1);
        end
        rst = 1'b0;
        adv(1);  check("por_e0", int'(bus.io_member_reset), 15);
        adv(15); check("por_e15", int'(bus.io_member_reset), 15);
        adv(1);  check("por_e16", int'(bus.io_member_reset), 14);
        adv(4);  check("por_e20", int'(bus.io_member_reset), 12);
        adv(4);  check("por_e24", int'(bus.io_member_reset), 8);
        adv(4);  check("por_e28", int'(bus.io_member_reset), 0);
                 check("por_done", int'(bus.io_done), 1);
        adv(1);  check("por_ready_e29", int'(bus.io_sw_req_ready), 1);
                 check("por_done_e29", int'(bus.io_done), 0);

        // Table of single soft requests
        for (int i = 0; i < 6; i++) begin
            int done_at;
            int first_at;
            int stray;
            done_at = -1; first_at = -1; stray = 0;
            bus.io_sw_req_valid = 1'b1;
            bus.io_sw_req_mask  = tv[i].mask;
            adv(1);
            bus.io_sw_req_valid = 1'b0;
            check($sformatf("vec%0d_accept", i), int'(bus.io_member_reset), int'(tv[i].acc));
            check($sformatf("vec%0d_ready_low", i), int'(bus.io_sw_req_ready), 0);
            for (int k = 1; k <= 64; k++) begin
                adv(1);
                if (first_at < 0 && bus.io_member_reset != tv[i].acc) first_at = k;
                if ((bus.io_member_reset & ~tv[i].mask) != '0) stray++;
                if (bus.io_done === 1'b1) begin
                    done_at = k;
                    break;
                end
            end
            check($sformatf("vec%0d_done_offset", i), done_at, tv[i].done_off);
            check($sformatf("vec%0d_first_fall", i), first_at, tv[i].first_fall);
            check($sformatf("vec%0d_unmasked_touched", i), stray, 0);
            adv(1);
            check($sformatf("vec%0d_ready_after", i), int'(bus.io_sw_req_ready), 1);
        end

        // Valid held high: periodic 16-high / 2-low pattern on member 0
        bus.io_sw_req_valid = 1'b1;
        bus.io_sw_req_mask  = 4'b0001;
        adv(1);
        check("rep_start", int'(bus.io_member_reset), 1);
        for (int p = 0; p < 2; p++) begin
            adv(15); check($sformatf("rep%0d_hold", p), int'(bus.io_member_reset), 1);
                     check($sformatf("rep%0d_ready_busy", p), int'(bus.io_sw_req_ready), 0);
            adv(1);  check($sformatf("rep%0d_fall", p), int'(bus.io_member_reset), 0);
                     check($sformatf("rep%0d_done", p), int'(bus.io_done), 1);
            adv(1);  check($sformatf("rep%0d_idle", p), int'(bus.io_sw_req_ready), 1);
            adv(1);  check($sformatf("rep%0d_rearm", p), int'(bus.io_member_reset), 1);
        end
        bus.io_sw_req_valid = 1'b0;
        wait_idle("rep_idle");

        // Group reset during RELEASE restarts the full power-on sequence
        bus.io_sw_req_valid = 1'b1;
        bus.io_sw_req_mask  = 4'b1111;
        adv(1);
        bus.io_sw_req_valid = 1'b0;
        adv(20); check("mid_release", int'(bus.io_member_reset), 12);
        rst = 1'b1;
        adv(1);  check("mid_reset_all", int'(bus.io_member_reset), 15);
                 check("mid_reset_busy", int'(bus.io_busy), 1);
        rst = 1'b0;
        adv(1);  check("mid_r0", int'(bus.io_member_reset), 15);
        adv(15); check("mid_r15", int'(bus.io_member_reset), 15);
        adv(1);  check("mid_r16", int'(bus.io_member_reset), 14);
        wait_idle("mid_idle");

        // Request with a new mask during ASSERT waits for the current sequence
        bus.io_sw_req_valid = 1'b1;
        bus.io_sw_req_mask  = 4'b0011;
        adv(1);  check("pend_start", int'(bus.io_member_reset), 3);
        bus.io_sw_req_mask  = 4'b1100;
        adv(15); check("pend_hold", int'(bus.io_member_reset), 3);
        adv(1);  check("pend_fall0", int'(bus.io_member_reset), 2);
        adv(4);  check("pend_fall1", int'(bus.io_member_reset), 0);
                 check("pend_done", int'(bus.io_done), 1);
        adv(1);  check("pend_idle", int'(bus.io_sw_req_ready), 1);
        adv(1);  check("pend_new_mask", int'(bus.io_member_reset), 12);
        bus.io_sw_req_valid = 1'b0;
        adv(16); check("pend_new_fall", int'(bus.io_member_reset), 8);
        wait_idle("pend_end");

        // Randomized traffic, checked cycle by cycle by the model
        for (int c = 0; c < 3000; c++) begin
            rst                 = ($urandom_range(0, 199) == 0);
            bus.io_sw_req_valid = ($urandom_range(0, 2) == 0);
            bus.io_sw_req_mask  = N'($urandom);
            adv(1);
        end
        rst = 1'b0;
        bus.io_sw_req_valid = 1'b0;
        wait_idle("rand_end");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
